sevenseg_scanner: RTL



---
 rtl/sevenseg_pkg.sv | 58 +++++
 rtl/hex_to_seg7.sv | 13 +
 rtl/sevenseg_scanner.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment display paths: segment bit
// positions, the active-high hex glyph table and the output polarity helper.
package sevenseg_pkg;

  // Segment bit positions inside a 7-bit glyph (bit0 = a ... bit6 = g).
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Builds a glyph from individual segment flags, listed in a..g order.
  function automatic logic [6:0] seg_bits(input logic a, input logic b,
                                          input logic c, input logic d,
                                          input logic e, input logic f,
                                          input logic g);
    logic [6:0] s;
    s        = '0;
    s[SEG_A] = a;
    s[SEG_B] = b;
    s[SEG_C] = c;
    s[SEG_D] = d;
    s[SEG_E] = e;
    s[SEG_F] = f;
    s[SEG_G] = g;
    return s;
  endfunction

  // Active-high glyphs for 0..F; b and d are the lowercase forms so they
  // cannot be confused with 8 and 0.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    seg_bits(1, 1, 1, 1, 1, 1, 0),  // 0
    seg_bits(0, 1, 1, 0, 0, 0, 0),  // 1
    seg_bits(1, 1, 0, 1, 1, 0, 1),  // 2
    seg_bits(1, 1, 1, 1, 0, 0, 1),  // 3
    seg_bits(0, 1, 1, 0, 0, 1, 1),  // 4
    seg_bits(1, 0, 1, 1, 0, 1, 1),  // 5
    seg_bits(1, 0, 1, 1, 1, 1, 1),  // 6
    seg_bits(1, 1, 1, 0, 0, 0, 0),  // 7
    seg_bits(1, 1, 1, 1, 1, 1, 1),  // 8
    seg_bits(1, 1, 1, 1, 0, 1, 1),  // 9
    seg_bits(1, 1, 1, 0, 1, 1, 1),  // A
    seg_bits(0, 0, 1, 1, 1, 1, 1),  // b
    seg_bits(1, 0, 0, 1, 1, 1, 0),  // C
    seg_bits(0, 1, 1, 1, 1, 0, 1),  // d
    seg_bits(1, 0, 0, 1, 1, 1, 1),  // E
    seg_bits(1, 0, 0, 0, 1, 1, 1)   // F
  };

  // Maps an active-high drive bit onto the pin polarity of the board.
  function automatic logic apply_pol(input logic active_high_val,
                                     input bit   active_low);
    return active_low ? ~active_high_val : active_high_val;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-glyph decoder (active-high), shared by every
// display path that needs a hex digit on a seven-segment element.
module hex_to_seg7
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Straight table lookup; the table covers all 16 codes so no default is needed.
  assign seg_o = HEX_GLYPH[nibble_i];

endmodule

// File: rtl/sevenseg_scanner.sv
// Time-multiplexed seven-segment scanner: walks one digit at a time through
// NUM_DIGITS anodes, with a dead-time gap at the start of every slot,
// leading-zero suppression, blanking, per-digit enables and a frame-aligned
// double buffer so a new value never tears across a scan.
module sevenseg_scanner
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_DIV        = 100000,
  parameter int DEAD_CYCLES    = 2,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit CAT_ACTIVE_LOW = 1'b1
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] Data,
  input  logic                    Load,
  input  logic [NUM_DIGITS-1:0]   DigitEn,
  input  logic                    LZS,
  input  logic                    Blank,
  output logic [NUM_DIGITS-1:0]   SevenSegAn,
  output logic [6:0]              SevenSegCat,
  output logic                    Frame
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Pin levels for "nothing driven" under the selected polarities.
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{apply_pol(1'b0, AN_ACTIVE_LOW)}};
  localparam logic [6:0]            CAT_OFF = {7{apply_pol(1'b0, CAT_ACTIVE_LOW)}};

  // Scan position
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cnt_wrap;
  logic             frame_edge;

  // Double-buffered display data
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    pend_v_q, pend_v_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;

  // Current-digit decode
  logic [3:0]            cur_nib;
  logic                  cur_en;
  logic                  upper_nz;
  logic                  suppressed;
  logic                  visible;
  logic [6:0]            glyph;
  logic [NUM_DIGITS-1:0] an_hi;
  logic [6:0]            cat_hi;

  // Registered outputs
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            cat_q, cat_d;
  logic                  frame_pend_q;
  logic                  frame_q;

  assign cnt_wrap   = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign frame_edge = cnt_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));

  // Prescaler and digit index: idx steps once per slot and wraps on the frame edge.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a value held and no latch is inferred.
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_wrap) begin
      cnt_d = '0;
      idx_d = frame_edge ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Pending/shadow buffer: Load fills pend; the frame edge publishes it. A Load
  // landing exactly on the frame edge bypasses pend and goes straight to shadow.
  always_comb begin
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    shadow_d = shadow_q;
    if (Load) begin
      pend_d   = Data;
      pend_v_d = 1'b1;
    end
    if (frame_edge) begin
      pend_v_d = 1'b0;
      if (Load) begin
        shadow_d = Data;
      end else if (pend_v_q) begin
        shadow_d = pend_q;
      end
    end
  end

  // Select the current digit's nibble/enable and look for any non-zero nibble
  // at or above it, which is what decides leading-zero suppression.
  always_comb begin
    cur_nib  = '0;
    cur_en   = 1'b0;
    upper_nz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib = shadow_q[i*4 +: 4];
        cur_en  = DigitEn[i];
      end
      if ((IDX_W'(i) >= idx_q) && (shadow_q[i*4 +: 4] != 4'h0)) begin
        upper_nz = 1'b1;
      end
    end
  end

  hex_to_seg7 u_dec (
    .nibble_i (cur_nib),
    .seg_o    (glyph)
  );

  // Visibility and active-high drive, then polarity applied bit by bit.
  always_comb begin
    // Digit 0 is never suppressed so an all-zero value still shows one "0".
    suppressed = LZS && (idx_q != '0) && !upper_nz;
    visible    = (int'({1'b0, cnt_q}) >= DEAD_CYCLES) && cur_en && !Blank && !suppressed;
    an_hi      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_hi[i] = visible && (idx_q == IDX_W'(i));
    end
    cat_hi = visible ? glyph : 7'h00;
    an_d   = AN_OFF;
    cat_d  = CAT_OFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = apply_pol(an_hi[i], AN_ACTIVE_LOW);
    end
    for (int i = 0; i < 7; i++) begin
      cat_d[i] = apply_pol(cat_hi[i], CAT_ACTIVE_LOW);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (Reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      // NOTE: pend/shadow are plain flops, not a RAM, so they take the reset;
      // this is what makes the first frame after reset show zeros and what
      // discards a Load that was still pending when reset arrived.
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      shadow_q     <= '0;
      an_q         <= AN_OFF;
      cat_q        <= CAT_OFF;
      frame_pend_q <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      shadow_q     <= shadow_d;
      an_q         <= an_d;
      cat_q        <= cat_d;
      // Frame is two stages behind the wrap: one for the counters to reach
      // digit 0 slot 0, one for the output flops to show it. Keying it on
      // a real wrap means no pulse on the first cycle out of reset.
      frame_pend_q <= frame_edge;
      frame_q      <= frame_pend_q;
    end
  end

  assign SevenSegAn  = an_q;
  assign SevenSegCat = cat_q;
  assign Frame       = frame_q;

endmodule
